// File: rtl/glitch_event_monitor_pkg.sv
// Shared types for the glitch event monitor: FSM encoding and event record layout.
package glitch_mon_pkg;

  localparam int unsigned OFFSET_W   = 16;
  localparam int unsigned PULSE_W    = 8;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned ERR_W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PULSE = 2'd2
  } state_t;

  // Event record as stored in the FIFO: offset in the upper bits, width below.
  typedef struct packed {
    logic [OFFSET_W-1:0] offset;
    logic [PULSE_W-1:0]  width;
  } evt_rec_t;

endpackage

// File: rtl/glitch_event_monitor_if.sv
// Event drain bus between the glitch monitor (master) and the cocotb reader (slave).
interface glitch_evt_if
  import glitch_mon_pkg::*;
#(
  parameter int unsigned pOFFSET_WIDTH = OFFSET_W,
  parameter int unsigned pPULSE_WIDTH  = PULSE_W,
  parameter int unsigned pFIFO_DEPTH   = FIFO_DEPTH
);
  logic                         evt_rd;
  logic                         evt_valid;
  logic [pOFFSET_WIDTH-1:0]     evt_offset;
  logic [pPULSE_WIDTH-1:0]      evt_width;
  logic [$clog2(pFIFO_DEPTH):0] fifo_count;
  logic                         evt_overflow;

  modport master (
    input  evt_rd,
    output evt_valid, evt_offset, evt_width, fifo_count, evt_overflow
  );

  modport slave (
    output evt_rd,
    input  evt_valid, evt_offset, evt_width, fifo_count, evt_overflow
  );
endinterface

// File: rtl/glitch_evt_fifo.sv
// Synchronous first-word-fall-through FIFO of packed event records with sticky drop flag.
module glitch_evt_fifo #(
  parameter int unsigned pDATA_WIDTH = 24,
  parameter int unsigned pDEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    push,
  input  logic                    pop,
  input  logic [pDATA_WIDTH-1:0]  din,
  output logic                    valid,
  output logic [pDATA_WIDTH-1:0]  head,
  output logic [$clog2(pDEPTH):0] count,
  output logic                    overflow
);
  localparam int unsigned AW = $clog2(pDEPTH);
  localparam int unsigned CW = AW + 1;

  logic [pDATA_WIDTH-1:0] mem [pDEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   full_c;
  logic                   do_push_c;
  logic                   do_pop_c;
  logic [CW-1:0]          count_next_c;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    do_pop_c     = pop & (count != '0);
    full_c       = (count == CW'(pDEPTH));
    do_push_c    = push & (~full_c | do_pop_c);
    count_next_c = count + CW'(do_push_c) - CW'(do_pop_c);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next_c;
      valid <= (count_next_c != '0);
      if (push && !do_push_c) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !clr && do_push_c) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/glitch_event_monitor.sv
// Checks glitch_out against the reference every cycle and records each glitch pulse
// as an (offset-from-trigger, width) event for software to drain.
module glitch_event_monitor
  import glitch_mon_pkg::*;
#(
  parameter int unsigned pOFFSET_WIDTH = OFFSET_W,
  parameter int unsigned pPULSE_WIDTH  = PULSE_W,
  parameter int unsigned pFIFO_DEPTH   = FIFO_DEPTH,
  parameter int unsigned pERR_WIDTH    = ERR_W
) (
  input  logic                  glitch_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clr_stats,
  input  logic                  trigger,
  input  logic                  glitch_out,
  input  logic                  expected_glitch,
  glitch_evt_if.master          evt,
  output logic [pERR_WIDTH-1:0] error_count,
  output logic                  glitch_error,
  output logic                  busy
);
  localparam int unsigned REC_W = pOFFSET_WIDTH + pPULSE_WIDTH;

  state_t                   state;
  logic                     trigger_q;
  logic [pOFFSET_WIDTH-1:0] off_cnt;
  logic [pOFFSET_WIDTH-1:0] off_q;
  logic [pPULSE_WIDTH-1:0]  wid_q;

  logic                     trig_rise_c;
  logic                     mismatch_c;
  logic [pOFFSET_WIDTH-1:0] off_inc_c;
  logic [pOFFSET_WIDTH-1:0] off_next_c;
  logic [pPULSE_WIDTH-1:0]  wid_inc_c;
  logic                     push_c;
  logic [REC_W-1:0]         head_c;

  always_comb begin
    trig_rise_c = trigger & ~trigger_q;
    mismatch_c  = (glitch_out != expected_glitch);
    off_inc_c   = (off_cnt == '1) ? off_cnt : off_cnt + pOFFSET_WIDTH'(1);
    off_next_c  = trig_rise_c ? '0 : off_inc_c;
    wid_inc_c   = (wid_q == '1) ? wid_q : wid_q + pPULSE_WIDTH'(1);
    // Pulse ends on a low sample, or is cut short when the monitor is disabled.
    push_c      = (state == PULSE) & (~glitch_out | ~enable);
  end

  always_ff @(posedge glitch_clk) begin
    if (reset) begin
      trigger_q    <= 1'b0;
      glitch_error <= 1'b0;
    end else begin
      trigger_q    <= trigger;
      glitch_error <= enable & mismatch_c;
    end
  end

  always_ff @(posedge glitch_clk) begin
    if (reset || clr_stats) begin
      error_count <= '0;
    end else if (enable && mismatch_c && (error_count != '1)) begin
      error_count <= error_count + pERR_WIDTH'(1);
    end
  end

  // Pulse measurement FSM; busy is registered alongside the state.
  always_ff @(posedge glitch_clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      off_cnt <= '0;
      off_q   <= '0;
      wid_q   <= '0;
    end else if (!enable) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trig_rise_c) begin
            off_cnt <= '0;
            busy    <= 1'b1;
            if (glitch_out) begin
              state <= PULSE;
              off_q <= '0;
              wid_q <= pPULSE_WIDTH'(1);
            end else begin
              state <= ARMED;
            end
          end
        end
        ARMED: begin
          off_cnt <= off_next_c;
          if (glitch_out) begin
            state <= PULSE;
            off_q <= off_next_c;
            wid_q <= pPULSE_WIDTH'(1);
          end
        end
        PULSE: begin
          off_cnt <= off_inc_c;
          if (glitch_out) wid_q <= wid_inc_c;
          else            state <= ARMED;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  glitch_evt_fifo #(
    .pDATA_WIDTH (REC_W),
    .pDEPTH      (pFIFO_DEPTH)
  ) u_fifo (
    .clk      (glitch_clk),
    .reset    (reset),
    .clr      (clr_stats),
    .push     (push_c),
    .pop      (evt.evt_rd),
    .din      ({off_q, wid_q}),
    .valid    (evt.evt_valid),
    .head     (head_c),
    .count    (evt.fifo_count),
    .overflow (evt.evt_overflow)
  );

  assign evt.evt_offset = head_c[REC_W-1 -: pOFFSET_WIDTH];
  assign evt.evt_width  = head_c[pPULSE_WIDTH-1:0];

endmodule

// File: tb/tb_glitch_event_monitor.sv
// Directed bench for glitch_event_monitor: compare, event records, FIFO limits, saturation, abort/clear.
module tb_glitch_event_monitor;

  logic        glitch_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clr_stats;
  logic        trigger;
  logic        glitch_out;
  logic        expected_glitch;
  logic [31:0] error_count;
  logic        glitch_error;
  logic        busy;

  int checks = 0;
  int errors = 0;

  glitch_evt_if evt_bus ();

  glitch_event_monitor dut (
    .glitch_clk      (glitch_clk),
    .reset           (reset),
    .enable          (enable),
    .clr_stats       (clr_stats),
    .trigger         (trigger),
    .glitch_out      (glitch_out),
    .expected_glitch (expected_glitch),
    .evt             (evt_bus),
    .error_count     (error_count),
    .glitch_error    (glitch_error),
    .busy            (busy)
  );

  always #5 glitch_clk = ~glitch_clk;

  // Inputs are driven before the edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge glitch_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input int off, input int wid);
    check({tag, " valid"},  64'(evt_bus.evt_valid),  64'd1);
    check({tag, " offset"}, 64'(evt_bus.evt_offset), 64'(off));
    check({tag, " width"},  64'(evt_bus.evt_width),  64'(wid));
  endtask

  // Trigger rise, first glitch sample 'gap' edges later, 'width' high samples, then one low.
  task automatic run_pulse(input int gap, input int width);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (gap - 1) tick();
    glitch_out = 1'b1; expected_glitch = 1'b1;
    repeat (width) tick();
    glitch_out = 1'b0; expected_glitch = 1'b0;
    tick();
  endtask

  task automatic pop();
    evt_bus.evt_rd = 1'b1;
    tick();
    evt_bus.evt_rd = 1'b0;
  endtask

  initial begin
    // Reset with random inputs
    reset = 1'b1;
    evt_bus.evt_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enable          = 1'($urandom);
      clr_stats       = 1'($urandom);
      trigger         = 1'($urandom);
      glitch_out      = 1'($urandom);
      expected_glitch = 1'($urandom);
      evt_bus.evt_rd  = 1'($urandom);
      tick();
    end
    check("rst busy",        64'(busy),                 64'd0);
    check("rst fifo_count",  64'(evt_bus.fifo_count),   64'd0);
    check("rst evt_valid",   64'(evt_bus.evt_valid),    64'd0);
    check("rst overflow",    64'(evt_bus.evt_overflow), 64'd0);
    check("rst error_count", 64'(error_count),          64'd0);
    check("rst glitch_error",64'(glitch_error),         64'd0);

    reset = 1'b0; enable = 1'b0; clr_stats = 1'b0; trigger = 1'b0;
    glitch_out = 1'b0; expected_glitch = 1'b0; evt_bus.evt_rd = 1'b0;
    tick();
    enable = 1'b1;
    tick();

    // Single pulse: trigger at edge 0, glitch on edges 5..7
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("single busy", 64'(busy), 64'd1);
    repeat (4) tick();
    glitch_out = 1'b1; expected_glitch = 1'b1;
    repeat (3) tick();
    check("single valid before end", 64'(evt_bus.evt_valid), 64'd0);
    glitch_out = 1'b0; expected_glitch = 1'b0;
    tick();
    check_head("single", 5, 3);
    check("single count", 64'(evt_bus.fifo_count), 64'd1);
    check("single errors", 64'(error_count), 64'd0);
    pop();
    check("single popped count", 64'(evt_bus.fifo_count), 64'd0);
    check("single popped valid", 64'(evt_bus.evt_valid), 64'd0);

    // Mismatch on edge 7 only
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (4) tick();
    glitch_out = 1'b1; expected_glitch = 1'b1;
    repeat (2) tick();
    check("mismatch no error yet", 64'(glitch_error), 64'd0);
    expected_glitch = 1'b0;
    tick();
    check("mismatch glitch_error", 64'(glitch_error), 64'd1);
    check("mismatch count", 64'(error_count), 64'd1);
    glitch_out = 1'b0;
    tick();
    check("mismatch glitch_error clears", 64'(glitch_error), 64'd0);
    check("mismatch count holds", 64'(error_count), 64'd1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr error_count", 64'(error_count), 64'd0);
    check("clr fifo_count", 64'(evt_bus.fifo_count), 64'd0);

    // Overflow: 9 pulses with offsets 2..10, widths 1..9
    for (int i = 0; i < 8; i++) run_pulse(2 + i, 1 + i);
    check("ovf count at 8", 64'(evt_bus.fifo_count), 64'd8);
    check("ovf flag before drop", 64'(evt_bus.evt_overflow), 64'd0);
    run_pulse(10, 9);
    check("ovf count", 64'(evt_bus.fifo_count), 64'd8);
    check("ovf flag", 64'(evt_bus.evt_overflow), 64'd1);
    check_head("ovf head", 2, 1);

    // Full FIFO: pop and push on the same edge (new record offset 1, width 1)
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    glitch_out = 1'b1; expected_glitch = 1'b1;
    tick();
    glitch_out = 1'b0; expected_glitch = 1'b0;
    evt_bus.evt_rd = 1'b1;
    tick();
    evt_bus.evt_rd = 1'b0;
    check("ovf push+pop count", 64'(evt_bus.fifo_count), 64'd8);
    for (int i = 1; i < 8; i++) begin
      check_head("ovf drain", 2 + i, 1 + i);
      pop();
    end
    check_head("ovf drain last", 1, 1);
    pop();
    check("ovf drained", 64'(evt_bus.fifo_count), 64'd0);
    check("ovf sticky", 64'(evt_bus.evt_overflow), 64'd1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("ovf cleared", 64'(evt_bus.evt_overflow), 64'd0);

    // Width saturation
    run_pulse(1, 300);
    check_head("wid sat", 1, 255);
    pop();

    // Offset saturation
    run_pulse(70000, 1);
    check_head("off sat", 65535, 1);
    pop();

    // Abort: enable drops at width 4 with glitch still high
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    glitch_out = 1'b1; expected_glitch = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    tick();
    check("abort busy", 64'(busy), 64'd0);
    check("abort count", 64'(evt_bus.fifo_count), 64'd1);
    check_head("abort", 1, 4);
    glitch_out = 1'b0; expected_glitch = 1'b0;
    enable = 1'b1;
    tick();

    // clr_stats on the same edge as a push, with one mismatch recorded first
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    glitch_out = 1'b1; expected_glitch = 1'b0;
    tick();
    check("clr pre errors", 64'(error_count), 64'd1);
    check("clr pre count", 64'(evt_bus.fifo_count), 64'd1);
    glitch_out = 1'b0;
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr push count", 64'(evt_bus.fifo_count), 64'd0);
    check("clr push valid", 64'(evt_bus.evt_valid), 64'd0);
    check("clr push errors", 64'(error_count), 64'd0);
    check("clr push overflow", 64'(evt_bus.evt_overflow), 64'd0);
    tick();
    check("clr stays empty", 64'(evt_bus.fifo_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/glitch_event_monitor.md
Name: glitch_event_monitor

Overview:
- Sits directly downstream of the DUT's glitch output in the CW310 Husky cocotb wrapper, clocked by glitch_clk.
- Compares glitch_out against expected_glitch every cycle and keeps a saturating mismatch count.
- Measures each glitch pulse as an (offset-from-trigger, width) record and queues records in a small FIFO for cocotb to drain.
- Replaces the ad-hoc flopped glitch_error compare with one checkable block.

Parameters:
- pOFFSET_WIDTH, 16: width of the offset counter and evt_offset.
- pPULSE_WIDTH, 8: width of the pulse-width counter and evt_width.
- pFIFO_DEPTH, 8: event FIFO depth; must be a power of 2, minimum 2.
- pERR_WIDTH, 32: width of error_count.

Ports:
- glitch_clk  in  1  sole clock; all inputs sampled on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- enable  in  1  monitor enable; low forces IDLE and freezes error counting.
- clr_stats  in  1  synchronous clear of error_count, evt_overflow and FIFO; state machine unaffected.
- trigger  in  1  target trigger; a sampled rising edge starts offset timing.
- glitch_out  in  1  DUT glitch output.
- expected_glitch  in  1  reference model glitch value.
- evt_rd  in  1  pop request for the FIFO head.
- evt_valid  out  1  FIFO non-empty; head record is presented (first-word-fall-through).
- evt_offset  out  pOFFSET_WIDTH  head record offset.
- evt_width  out  pPULSE_WIDTH  head record width.
- fifo_count  out  clog2(pFIFO_DEPTH)+1  number of records held.
- evt_overflow  out  1  sticky: a record was dropped.
- error_count  out  pERR_WIDTH  saturating mismatch count.
- glitch_error  out  1  registered (glitch_out != expected_glitch).
- busy  out  1  state != IDLE.

Behaviour:
- Reset: every output is 0, state IDLE, FIFO empty, trigger history register = 0.
- Trigger edge: trig_rise = trigger & ~trigger_q, where trigger_q is last edge's sample.
- Compare, when enable = 1:
  - glitch_error <= (glitch_out != expected_glitch).
  - error_count increments on each mismatching edge and saturates at all-ones.
- Compare, when enable = 0: glitch_error <= 0; error_count holds.
- Offset: for a trigger-rise edge T and the first edge G sampling glitch_out = 1, offset = G - T. Saturates at 2^pOFFSET_WIDTH - 1.
- Width: number of consecutive edges sampling glitch_out = 1. Saturates at 2^pPULSE_WIDTH - 1.
- FSM, state IDLE:
  - enable & trig_rise & glitch_out -> PULSE, offset 0, width 1.
  - enable & trig_rise -> ARMED, offset counter 0.
  - Otherwise stay in IDLE; glitches before any trigger are ignored.
- FSM, state ARMED:
  - offset counter increments each edge (saturating); trig_rise reloads it to 0.
  - glitch_out = 1 -> PULSE; latch offset (0 if trig_rise on the same edge); width = 1.
- FSM, state PULSE:
  - glitch_out = 1: width increments (saturating); offset counter keeps running; trig_rise ignored.
  - glitch_out = 0: push record, go to ARMED.
- FSM, any state: enable = 0 -> IDLE. If leaving PULSE this way, the partial record (width so far) is pushed.
- FIFO timing:
  - A push takes effect on the edge that detects the pulse end.
  - evt_valid, evt_offset and evt_width reflect the new head from the following cycle.
- Pop: evt_rd & evt_valid pops the head; evt_rd on an empty FIFO is ignored.
- Full FIFO:
  - push without pop: record dropped, evt_overflow <= 1.
  - push and pop on the same edge: both happen, count unchanged, no drop.
- Non-full FIFO, push and pop on the same edge: count unchanged.
- clr_stats:
  - overrides any push, pop or increment on the same edge.
  - result: FIFO empty, error_count 0, evt_overflow 0.
- reset mid-pulse: record is discarded and everything returns to reset values.

Decomposition:
- Package glitch_mon_pkg holds:
  - state encoding constants: IDLE, ARMED, PULSE.
  - record field widths and the packed record layout {offset, width}.
- One sub-module, glitch_evt_fifo: synchronous FWFT FIFO of packed records, with count, full/empty, drop flag and clear.

Test Plan:
- Reset: assert reset for 3 cycles with random inputs -> all outputs 0, busy 0, fifo_count 0.
- Single pulse:
  - Stimulus: enable = 1, trig_rise at edge 0, glitch_out high at edges 5-7, expected matches.
  - Response: one record, offset 5, width 3; evt_valid high from the cycle after edge 8; error_count 0.
- Mismatch: same stimulus, but expected_glitch high only at edges 5-6 -> error_count = 1, glitch_error high for exactly one cycle after edge 7.
- Overflow (depth 8):
  - Stimulus: 9 pulses, no reads.
  - Response: fifo_count 8, evt_overflow 1, records 1-8 intact.
  - Follow-up: pop and push on the same edge -> count stays 8, no additional loss.
- Saturation: glitch_out high for 300 edges -> width 255. No glitch for 70000 edges after trigger -> a later glitch reports offset 65535.
- Abort and clear:
  - enable drops at pulse width 4 -> record width 4 pushed, busy 0 on the next cycle.
  - Then clr_stats coincident with a push -> fifo_count 0, error_count 0, evt_overflow 0.
